cook_sequencer: RTL

Master sequencer for the microwave timer datapath. Takes the BCD digit stream and 1 Hz tick from `control_input`, builds an MM:SS cook time from keypad entry, and runs the countdown in BCD. It gates the magnetron on start, stop and door events and reports completion. Its four BCD digit outputs feed the display decoders directly.

---
 rtl/microwave_pkg.sv | 26 ++
 rtl/bcd_mmss_decrement.sv | 48 ++++
 rtl/cook_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/microwave_pkg.sv
// microwave_pkg
//   Shared types and constants for the microwave cook sequencer.
//   - state_t : sequencer states (IDLE, ENTRY, COOK, PAUSE, DONE)
//   - bcd_t   : one BCD digit
//   - BCD_MAX / SEC_TENS_WRAP : digit limits used by entry and countdown
package microwave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    COOK,
    PAUSE,
    DONE
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX       = 4'd9;
  localparam bcd_t SEC_TENS_WRAP = 4'd5;

  // A keypad code is usable only when it is a real decimal digit.
  function automatic logic is_bcd_digit(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_mmss_decrement.sv
// bcd_mmss_decrement
//   Combinational one-second decrement of an MM:SS time held as four BCD
//   digits. Digits are not normalised: 1:75 steps down to 1:00 before the
//   minute borrow. 00:00 is returned unchanged.
// Ports:
//   i_min_tens/i_min_ones/i_sec_tens/i_sec_ones : current time (BCD)
//   o_min_tens/o_min_ones/o_sec_tens/o_sec_ones : time one second later
//   o_zero : 1 when the decremented time is 00:00
module bcd_mmss_decrement
  import microwave_pkg::*;
(
  input  logic [3:0] i_min_tens,
  input  logic [3:0] i_min_ones,
  input  logic [3:0] i_sec_tens,
  input  logic [3:0] i_sec_ones,
  output logic [3:0] o_min_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_sec_ones,
  output logic       o_zero
);

  always_comb begin
    o_min_tens = i_min_tens;
    o_min_ones = i_min_ones;
    o_sec_tens = i_sec_tens;
    o_sec_ones = i_sec_ones;
    if (i_sec_ones != 4'd0) begin
      o_sec_ones = i_sec_ones - 4'd1;
    end else if (i_sec_tens != 4'd0) begin
      o_sec_ones = BCD_MAX;
      o_sec_tens = i_sec_tens - 4'd1;
    end else if ((i_min_ones != 4'd0) || (i_min_tens != 4'd0)) begin
      // Seconds wrap to 59 and the minutes take the borrow.
      o_sec_ones = BCD_MAX;
      o_sec_tens = SEC_TENS_WRAP;
      if (i_min_ones != 4'd0) begin
        o_min_ones = i_min_ones - 4'd1;
      end else begin
        o_min_ones = BCD_MAX;
        o_min_tens = i_min_tens - 4'd1;
      end
    end
  end

  assign o_zero = ({o_min_tens, o_min_ones, o_sec_tens, o_sec_ones} == 16'd0);

endmodule

// File: rtl/cook_sequencer.sv
// cook_sequencer
//   Master sequencer for the microwave timer: keypad entry of an MM:SS cook
//   time, BCD countdown on the 1 Hz tick, magnetron gating on start, stop
//   and door events, and completion reporting.
//   Optional feature: define DONE_ALARM_EN to hold `alarm` for ALARM_TICKS
//   ticks in DONE; otherwise DONE is a single-clock `done` pulse and
//   `alarm` is tied low.
// Ports:
//   clock, clearn         : clock, async active-low reset
//   BCD, loadn            : keypad digit and its active-low strobe
//   pgt_1Hz               : 1 Hz square wave (rising edge = tick)
//   startn, stopn         : active-low buttons
//   door_closed           : 1 = door closed
//   sec_ones..min_tens    : current time, BCD, registered
//   key_en, mag_on, done, alarm : registered status outputs
module cook_sequencer
  import microwave_pkg::*;
#(
  parameter int ALARM_TICKS = 3
)
(
  input  logic       clock,
  input  logic       clearn,
  input  logic [3:0] BCD,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       key_en,
  output logic       mag_on,
  output logic       done,
  output logic       alarm
);

  state_t r_state;
  bcd_t   r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;
  logic   r_key_en, r_mag_on, r_done;
  logic   r_loadn_prev, r_pgt_prev, r_startn_prev, r_stopn_prev;

  logic   w_digit_ev, w_tick, w_start_ev, w_stop_ev;
  logic   w_digit_ok, w_time_zero;
  bcd_t   w_dec_sec_ones, w_dec_sec_tens, w_dec_min_ones, w_dec_min_tens;
  logic   w_dec_zero;

  // Edge detectors compare the live input with last cycle's sample.
  assign w_digit_ev  = r_loadn_prev & ~loadn;
  assign w_tick      = ~r_pgt_prev & pgt_1Hz;
  assign w_start_ev  = r_startn_prev & ~startn;
  assign w_stop_ev   = r_stopn_prev & ~stopn;
  assign w_digit_ok  = w_digit_ev & is_bcd_digit(BCD);
  assign w_time_zero = ({r_min_tens, r_min_ones, r_sec_tens, r_sec_ones} == 16'd0);

  bcd_mmss_decrement u_dec (
    .i_min_tens (r_min_tens),
    .i_min_ones (r_min_ones),
    .i_sec_tens (r_sec_tens),
    .i_sec_ones (r_sec_ones),
    .o_min_tens (w_dec_min_tens),
    .o_min_ones (w_dec_min_ones),
    .o_sec_tens (w_dec_sec_tens),
    .o_sec_ones (w_dec_sec_ones),
    .o_zero     (w_dec_zero)
  );

`ifdef DONE_ALARM_EN
  localparam int CNT_W = $clog2(ALARM_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALARM_TICKS - 1);
  logic             r_alarm;
  logic [CNT_W-1:0] r_alarm_cnt;
`endif

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      r_state       <= IDLE;
      r_sec_ones    <= '0;
      r_sec_tens    <= '0;
      r_min_ones    <= '0;
      r_min_tens    <= '0;
      r_key_en      <= 1'b1;
      r_mag_on      <= 1'b0;
      r_done        <= 1'b0;
      r_loadn_prev  <= 1'b1;
      r_pgt_prev    <= 1'b0;
      r_startn_prev <= 1'b1;
      r_stopn_prev  <= 1'b1;
`ifdef DONE_ALARM_EN
      r_alarm       <= 1'b0;
      r_alarm_cnt   <= '0;
`endif
    end else begin
      r_loadn_prev  <= loadn;
      r_pgt_prev    <= pgt_1Hz;
      r_startn_prev <= startn;
      r_stopn_prev  <= stopn;

      case (r_state)
        IDLE: begin
          if (w_digit_ok) begin
            r_min_tens <= r_min_ones;
            r_min_ones <= r_sec_tens;
            r_sec_tens <= r_sec_ones;
            r_sec_ones <= BCD;
            r_state    <= ENTRY;
          end
        end

        ENTRY: begin
          if (w_stop_ev) begin
            {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones} <= '0;
            r_state <= IDLE;
          end else if (w_start_ev && door_closed && !w_time_zero) begin
            r_state  <= COOK;
            r_mag_on <= 1'b1;
            r_key_en <= 1'b0;
          end else if (w_digit_ok) begin
            // A rejected start leaves the cycle free for a digit.
            r_min_tens <= r_min_ones;
            r_min_ones <= r_sec_tens;
            r_sec_tens <= r_sec_ones;
            r_sec_ones <= BCD;
          end
        end

        COOK: begin
          // Stop or an open door wins over a coincident tick.
          if (w_stop_ev || !door_closed) begin
            r_state  <= PAUSE;
            r_mag_on <= 1'b0;
          end else if (w_tick) begin
            r_min_tens <= w_dec_min_tens;
            r_min_ones <= w_dec_min_ones;
            r_sec_tens <= w_dec_sec_tens;
            r_sec_ones <= w_dec_sec_ones;
            if (w_dec_zero) begin
              r_state  <= DONE;
              r_mag_on <= 1'b0;
              r_done   <= 1'b1;
`ifdef DONE_ALARM_EN
              r_alarm     <= 1'b1;
              r_alarm_cnt <= '0;
`endif
            end
          end
        end

        PAUSE: begin
          if (w_stop_ev) begin
            {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones} <= '0;
            r_state  <= IDLE;
            r_key_en <= 1'b1;
          end else if (w_start_ev && door_closed) begin
            r_state  <= COOK;
            r_mag_on <= 1'b1;
          end
        end

        DONE: begin
`ifdef DONE_ALARM_EN
          if (w_stop_ev || (w_tick && (r_alarm_cnt == CNT_LAST))) begin
            r_state     <= IDLE;
            r_done      <= 1'b0;
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
            r_key_en    <= 1'b1;
          end else if (w_tick) begin
            r_alarm_cnt <= r_alarm_cnt + CNT_W'(1);
          end
`else
          r_state  <= IDLE;
          r_done   <= 1'b0;
          r_key_en <= 1'b1;
`endif
        end

        default: begin
          r_state  <= IDLE;
          r_mag_on <= 1'b0;
          r_done   <= 1'b0;
          r_key_en <= 1'b1;
        end
      endcase
    end
  end

  assign sec_ones = r_sec_ones;
  assign sec_tens = r_sec_tens;
  assign min_ones = r_min_ones;
  assign min_tens = r_min_tens;
  assign key_en   = r_key_en;
  assign mag_on   = r_mag_on;
  assign done     = r_done;
`ifdef DONE_ALARM_EN
  assign alarm    = r_alarm;
`else
  assign alarm    = 1'b0;
`endif

endmodule
